// File: rtl/servisia_boot_ctrl.sv
// ----------------------------------------------------------------------------
// servisia_boot_ctrl
//
// Boot sequencer sitting between the subservient core, the byte-wide SRAM
// controller and a byte-stream boot source (UART / SPI-flash receiver).
//
// Out of reset the block owns the SRAM port and copies BOOT_BYTES stream
// bytes into SRAM starting at BASE_ADDR while holding the core in reset.
// Once the image is loaded it spends one idle RELEASE cycle, then hands the
// SRAM port to the core and releases core reset (RUN, terminal until rst_i).
//
// Optional feature, macro SERVISIA_BOOT_CHECKSUM_EN:
//   After the image one extra check byte is taken from the stream. If the
//   8-bit sum of image bytes plus the check byte is zero the core is started.
//   Otherwise the block parks in ERROR with err_o=1 and the core held in
//   reset. Without the macro there is no CHECK/ERROR state and err_o=0.
//
// Handshake: a stream byte is transferred in every cycle where boot_valid_i
// and boot_ready_o are both high. boot_ready_o depends only on the FSM state,
// never on boot_valid_i, and the source may stall for any number of cycles.
//
// The FSM state is held in state_q (type state_t) for checkers to bind to.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   boot_valid_i/_data_i/_ready_o  boot byte stream
//   core_waddr_i/_wdata_i/_wen_i   core SRAM write request (honoured in RUN)
//   core_raddr_i/_ren_i            core SRAM read request  (honoured in RUN)
//   core_rdata_o        SRAM read data to core (straight from mem_rdata_i)
//   mem_addr_o/_wdata_o/_wen_o/_ren_o/_rdata_i  SRAM controller port
//   core_rst_o          active-high core reset (registered)
//   done_o              load completed, core running (registered)
//   err_o               checksum failure (registered; 0 without the feature)
// ----------------------------------------------------------------------------
module servisia_boot_ctrl #(
    parameter int unsigned AW         = 21,
    parameter int unsigned BOOT_BYTES = 1024,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          boot_valid_i,
    input  logic [7:0]    boot_data_i,
    output logic          boot_ready_o,
    input  logic [AW-1:0] core_waddr_i,
    input  logic [7:0]    core_wdata_i,
    input  logic          core_wen_i,
    input  logic [AW-1:0] core_raddr_i,
    input  logic          core_ren_i,
    output logic [7:0]    core_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_wen_o,
    output logic          mem_ren_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          core_rst_o,
    output logic          done_o,
    output logic          err_o
);

    // Counter must be able to hold BOOT_BYTES itself (value after the last
    // accepted byte), hence clog2(BOOT_BYTES+1), never narrower than 1 bit.
    localparam int unsigned CW = (BOOT_BYTES == 0) ? 1 : $clog2(BOOT_BYTES + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'((BOOT_BYTES == 0) ? 0 : BOOT_BYTES - 1);
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);

`ifdef SERVISIA_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_CHECK   = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2
    } state_t;
`endif

    // An empty image boots straight into RUN.
    localparam state_t RESET_STATE = (BOOT_BYTES == 0) ? ST_RUN : ST_LOAD;
    localparam logic   RESET_CORE_RST = (BOOT_BYTES == 0) ? 1'b0 : 1'b1;
    localparam logic   RESET_DONE     = (BOOT_BYTES == 0) ? 1'b1 : 1'b0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          core_rst_q;
    logic          done_q;
    logic          ready;

`ifdef SERVISIA_BOOT_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    sum_check;
    logic          err_q;
`endif

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            core_rst_q <= RESET_CORE_RST;
            done_q     <= RESET_DONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            // Status flags follow the next state so they change on the
            // very first cycle spent in RUN.
            core_rst_q <= (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
        end
    end

`ifdef SERVISIA_BOOT_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= (state_d == ST_ERROR);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next state, stream handshake and SRAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready       = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;
        mem_wen_o   = 1'b0;
        mem_ren_o   = 1'b0;
`ifdef SERVISIA_BOOT_CHECKSUM_EN
        sum_d       = sum_q;
        sum_check   = sum_q + boot_data_i;
`endif

        case (state_q)
            ST_LOAD: begin
                ready = 1'b1;
                if (boot_valid_i) begin
                    mem_wen_o   = 1'b1;
                    // Address wraps modulo 2**AW by truncation.
                    mem_addr_o  = BASE + AW'(cnt_q);
                    mem_wdata_o = boot_data_i;
                    cnt_d       = cnt_q + 1'b1;
`ifdef SERVISIA_BOOT_CHECKSUM_EN
                    sum_d       = sum_q + boot_data_i;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_RELEASE;
                    end
`endif
                end
            end

`ifdef SERVISIA_BOOT_CHECKSUM_EN
            // One check byte is consumed but never written to SRAM.
            ST_CHECK: begin
                ready = 1'b1;
                if (boot_valid_i) begin
                    state_d = (sum_check == 8'h00) ? ST_RELEASE : ST_ERROR;
                end
            end

            // Parked until rst_i; core stays in reset, SRAM untouched.
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
`endif

            // Single idle cycle separating loader and core SRAM ownership.
            ST_RELEASE: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                mem_wen_o   = core_wen_i;
                mem_ren_o   = core_ren_i;
                mem_wdata_o = core_wdata_i;
                // A simultaneous write takes the address bus.
                mem_addr_o  = core_wen_i ? core_waddr_i : core_raddr_i;
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign boot_ready_o = ready;
    assign core_rdata_o = mem_rdata_i;
    assign core_rst_o   = core_rst_q;
    assign done_o       = done_q;

`ifdef SERVISIA_BOOT_CHECKSUM_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/servisia_boot_ctrl.md
Name: servisia_boot_ctrl

Overview:
- Boot sequencer between the subservient core, the byte-wide SRAM controller and a byte-stream boot source (UART/SPI-flash receiver).
- After reset it owns the SRAM port and copies BOOT_BYTES bytes from the stream into SRAM starting at BASE_ADDR, holding the core in reset.
- When the load completes it hands the SRAM port to the core and releases core reset.

Parameters:
- AW, 21, SRAM byte address width.
- BOOT_BYTES, 1024, number of image bytes to load; legal range 0..2**AW.
- BASE_ADDR, 0, first SRAM byte address written.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- boot_valid_i  input  1  stream byte valid
- boot_data_i  input  8  stream byte
- boot_ready_o  output  1  stream byte accepted when valid&ready
- core_waddr_i  input  AW  core SRAM write address
- core_wdata_i  input  8  core SRAM write data
- core_wen_i  input  1  core SRAM write enable
- core_raddr_i  input  AW  core SRAM read address
- core_ren_i  input  1  core SRAM read enable
- core_rdata_o  output  8  SRAM read data to core
- mem_addr_o  output  AW  SRAM address
- mem_wdata_o  output  8  SRAM write data
- mem_wen_o  output  1  SRAM write enable
- mem_ren_o  output  1  SRAM read enable
- mem_rdata_i  input  8  SRAM read data
- core_rst_o  output  1  active-high core reset
- done_o  output  1  load completed, core running
- err_o  output  1  checksum failure (feature only; else tied 0)

Behaviour:
- Reset: state=LOAD (or RUN if BOOT_BYTES==0), cnt=0, core_rst_o=1, done_o=0, err_o=0. All three are registered.
- States: LOAD, [CHECK], RELEASE, RUN, [ERROR].
- LOAD:
  - boot_ready_o=1 (combinational from state).
  - On valid&ready: mem_wen_o=1, mem_addr_o=BASE_ADDR+cnt (AW bits, wraps modulo 2**AW), mem_wdata_o=boot_data_i, all combinational in the same cycle. cnt increments.
  - No valid: mem_wen_o=0 and cnt holds. Stalls of any length are allowed.
  - Byte with cnt==BOOT_BYTES-1 accepted: next state RELEASE (CHECK with feature).
- Core request gating:
  - Outside RUN, mem_ren_o=0 and all core_* inputs are ignored.
  - core_rdata_o=mem_rdata_i always.
- RELEASE: lasts one cycle, boot_ready_o=0, no SRAM access. Next state RUN.
- RUN:
  - core_rst_o=0 and done_o=1, registered on entry, so both change the first cycle in RUN.
  - boot_ready_o=0; stream bytes are ignored.
  - SRAM mux: mem_wen_o=core_wen_i, mem_ren_o=core_ren_i, mem_wdata_o=core_wdata_i. mem_addr_o=core_waddr_i if core_wen_i, else core_raddr_i (write wins).
  - RUN is terminal until rst_i.
- BOOT_BYTES==0: reset state is RUN, with core_rst_o=0 and done_o=1 from reset.
- BOOT_BYTES==2**AW: every address is written exactly once; last address is BASE_ADDR-1 mod 2**AW.
- rst_i mid-load: immediate return to reset values. SRAM contents are not cleared; the next load restarts at cnt=0.
- cnt width: clog2(BOOT_BYTES+1), minimum 1.

Optional Feature:
- Macro: SERVISIA_BOOT_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum is cleared on reset and adds every accepted image byte, modulo 256.
  - After the last image byte, state CHECK accepts exactly one more stream byte (boot_ready_o=1, mem_wen_o=0).
  - If (sum+byte)%256==0, next state RELEASE.
  - Otherwise next state ERROR: core_rst_o stays 1, err_o=1 registered, boot_ready_o=0, no SRAM access until rst_i.
- Disabled: no CHECK/ERROR states, no adder, err_o tied 0.

Test Plan:
- BOOT_BYTES=4, BASE_ADDR=0x100, stream 0x11,0x22,0x33,0x44 back-to-back -> writes 0x100..0x103 on four consecutive cycles; core_rst_o falls and done_o rises exactly 2 cycles after the last write; mem_ren_o=0 throughout the load.
- Same config, valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes, no write in cycles with valid=0, addresses contiguous.
- RUN, core_wen_i=1 waddr=0x5 raddr=0x9 -> mem_addr_o=0x5. Then wen=0, ren=1 -> mem_addr_o=0x9, mem_ren_o=1, core_rdata_o follows mem_rdata_i.
- During LOAD, core_wen_i=1 and core_ren_i=1 -> mem_ren_o=0, and mem_wen_o is only asserted by stream bytes.
- rst_i pulsed after 2 of 4 bytes, then 4 bytes streamed -> writes restart at 0x100; done_o only after the 4th byte of the second stream.
- With SERVISIA_BOOT_CHECKSUM_EN, stream 0x01,0x02,0x03,0x04 plus check byte 0xF6 -> RUN. With check byte 0x00 -> err_o=1, core_rst_o stays 1, boot_ready_o=0.
